// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the fetch-stage PC sequencer
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BR,
        SEL_RET,
        SEL_CALL,
        SEL_JMP
    } pc_sel_e;

    localparam int unsigned PC_RESET_VEC = 0;
    localparam int unsigned PC_INC       = 1;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control and status bundle between fetch control and the PC sequencer
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
) ();

    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jmp_en;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output stall, br_taken, br_target, jmp_en, call, ret, jmp_target,
        input  pc, pc_plus, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, br_taken, br_target, jmp_en, call, ret, jmp_target,
        output pc, pc_plus, ras_empty, ras_full, ras_ovf, ras_unf
    );

endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with sticky overflow and underflow pulse
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  ptr_up;
    logic [CNT_W-1:0]  count;

    // top_ptr always names the most recent entry; a push lands one slot above it,
    // which on a full stack is exactly the oldest entry being overwritten
    assign ptr_up   = top_ptr + 1'b1;
    assign top_data = mem[top_ptr];
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);

    // pointer, occupancy and error flags; a pop on an empty stack changes nothing but flags it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_ptr <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            unf <= pop && (count == '0);
            if (push) begin
                top_ptr <= ptr_up;
                if (count == FULL_CNT) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (pop && (count != '0)) begin
                top_ptr <= top_ptr - 1'b1;
                count   <= count - 1'b1;
            end
        end
    end

    // entry storage needs no reset: count gates every read that matters
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_up] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS fetch program counter; return-address stack built only when PC_RAS_EN is defined
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int unsigned RESET_VEC = PC_RESET_VEC,
    parameter int unsigned INC       = PC_INC,
    parameter int          RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);

    localparam logic [ADDR_W-1:0] RESET_W = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] INC_W   = ADDR_W'(INC);

    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two of at least 2");
    end

    pc_sel_e           sel;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus_q;
    logic [ADDR_W-1:0] ret_addr;

    // redirect priority; any redirect beats stall, ret beats a simultaneous call
    always_comb begin
        sel = SEL_SEQ;
        if (bus.br_taken) begin
            sel = SEL_BR;
        end else if (bus.ret) begin
            sel = SEL_RET;
        end else if (bus.call) begin
            sel = SEL_CALL;
        end else if (bus.jmp_en) begin
            sel = SEL_JMP;
        end else if (bus.stall) begin
            sel = SEL_HOLD;
        end
    end

`ifdef PC_RAS_EN
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;
    logic              push;
    logic              pop;

    // pushed return address is the already-registered pc + INC of the call itself
    assign push = (sel == SEL_CALL);
    assign pop  = (sel == SEL_RET);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus_q),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (bus.ras_full),
        .ovf       (bus.ras_ovf),
        .unf       (bus.ras_unf)
    );

    assign bus.ras_empty = ras_empty;
    assign ret_addr      = ras_empty ? bus.jmp_target : ras_top;
`else
    // without a stack a return is just an indirect jump through jmp_target
    assign ret_addr      = bus.jmp_target;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_ovf   = 1'b0;
    assign bus.ras_unf   = 1'b0;
`endif

    // next fetch address; sequential step reuses the registered pc + INC
    always_comb begin
        next_pc = pc_plus_q;
        case (sel)
            SEL_HOLD: next_pc = pc_q;
            SEL_BR:   next_pc = bus.br_target;
            SEL_RET:  next_pc = ret_addr;
            SEL_CALL: next_pc = bus.jmp_target;
            SEL_JMP:  next_pc = bus.jmp_target;
            default:  next_pc = pc_plus_q;
        endcase
    end

    // pc and pc_plus are registered together so pc_plus never lags pc
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_W;
            pc_plus_q <= RESET_W + INC_W;
        end else begin
            pc_q      <= next_pc;
            pc_plus_q <= next_pc + INC_W;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.pc_plus = pc_plus_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer, with or without PC_RAS_EN
module tb_pc_sequencer;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W    (32),
        .RESET_VEC (32'h100),
        .INC       (1),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_ctl();
        bus.stall      = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        bus.jmp_en     = 1'b0;
        bus.call       = 1'b0;
        bus.ret        = 1'b0;
        bus.jmp_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [31:0] a);
        clear_ctl();
        bus.jmp_en = 1'b1;
        bus.jmp_target = a;
        tick();
        clear_ctl();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_ctl();
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_vec++; if (bus.pc !== 32'h100) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h100); end
        n_vec++; if (bus.pc_plus !== 32'h101) begin n_err++; $display("FAIL reset_pc_plus: got %h want %h", bus.pc_plus, 32'h101); end
        n_vec++; if ({bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf} !== 4'b1000) begin n_err++; $display("FAIL reset_flags: got %b want 1000", {bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf}); end
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        n_vec++; if (bus.pc !== 32'h100) begin n_err++; $display("FAIL run_pc0: got %h want %h", bus.pc, 32'h100); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++; if (bus.pc !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL run_pc%0d: got %h want %h", i, bus.pc, 32'h100 + 32'(i)); end
            n_vec++; if (bus.pc_plus !== 32'h101 + 32'(i)) begin n_err++; $display("FAIL run_pc_plus%0d: got %h want %h", i, bus.pc_plus, 32'h101 + 32'(i)); end
        end
    endtask

    task automatic test_stall_branch();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.pc !== 32'h104) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, bus.pc, 32'h104); end
        end
        n_vec++; if (bus.pc_plus !== 32'h105) begin n_err++; $display("FAIL stall_pc_plus: got %h want %h", bus.pc_plus, 32'h105); end
        bus.br_taken = 1'b1;
        bus.br_target = 32'h200;
        tick();
        n_vec++; if (bus.pc !== 32'h200) begin n_err++; $display("FAIL stall_branch_pc: got %h want %h", bus.pc, 32'h200); end
        n_vec++; if (bus.pc_plus !== 32'h201) begin n_err++; $display("FAIL stall_branch_pc_plus: got %h want %h", bus.pc_plus, 32'h201); end
        bus.br_taken = 1'b0;
        bus.jmp_en = 1'b1;
        bus.jmp_target = 32'h2A0;
        tick();
        n_vec++; if (bus.pc !== 32'h2A0) begin n_err++; $display("FAIL stall_jump_pc: got %h want %h", bus.pc, 32'h2A0); end
        bus.br_taken = 1'b1;
        bus.br_target = 32'h2C0;
        tick();
        n_vec++; if (bus.pc !== 32'h2C0) begin n_err++; $display("FAIL br_over_jmp_pc: got %h want %h", bus.pc, 32'h2C0); end
        clear_ctl();
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFF);
        n_vec++; if (bus.pc_plus !== 32'h0) begin n_err++; $display("FAIL wrap_pc_plus_at_max: got %h want %h", bus.pc_plus, 32'h0); end
        tick();
        n_vec++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 32'h0); end
        n_vec++; if (bus.pc_plus !== 32'h1) begin n_err++; $display("FAIL wrap_pc_plus: got %h want %h", bus.pc_plus, 32'h1); end
    endtask

    task automatic test_call_ret();
        jump_to(32'h10);
        bus.call = 1'b1;
        bus.jmp_target = 32'h80;
        tick();
        clear_ctl();
        n_vec++; if (bus.pc !== 32'h80) begin n_err++; $display("FAIL call_pc: got %h want %h", bus.pc, 32'h80); end
        n_vec++; if (bus.ras_empty !== !RAS) begin n_err++; $display("FAIL call_ras_empty: got %b want %b", bus.ras_empty, !RAS); end
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (bus.pc !== 32'h85) begin n_err++; $display("FAIL call_body_pc: got %h want %h", bus.pc, 32'h85); end
        bus.ret = 1'b1;
        bus.jmp_target = 32'h300;
        tick();
        clear_ctl();
        n_vec++; if (bus.pc !== (RAS ? 32'h11 : 32'h300)) begin n_err++; $display("FAIL ret_pc: got %h want %h", bus.pc, (RAS ? 32'h11 : 32'h300)); end
        n_vec++; if (bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL ret_ras_empty: got %b want 1", bus.ras_empty); end
        n_vec++; if (bus.ras_unf !== 1'b0) begin n_err++; $display("FAIL ret_ras_unf: got %b want 0", bus.ras_unf); end
        bus.call = 1'b1;
        bus.ret = 1'b1;
        bus.jmp_target = 32'h90;
        tick();
        clear_ctl();
        n_vec++; if (bus.pc !== 32'h90) begin n_err++; $display("FAIL call_ret_pc: got %h want %h", bus.pc, 32'h90); end
        n_vec++; if (bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL call_ret_no_push: got %b want 1", bus.ras_empty); end
        bus.br_taken = 1'b1;
        bus.br_target = 32'h220;
        bus.call = 1'b1;
        bus.jmp_target = 32'h240;
        tick();
        clear_ctl();
        n_vec++; if (bus.pc !== 32'h220) begin n_err++; $display("FAIL br_call_pc: got %h want %h", bus.pc, 32'h220); end
        n_vec++; if (bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL br_call_no_push: got %b want 1", bus.ras_empty); end
    endtask

    task automatic test_ovf_unf();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h41;
        exp_ret[1] = 32'h31;
        exp_ret[2] = 32'h21;
        exp_ret[3] = 32'h11;
        jump_to(32'h0);
        for (int i = 1; i <= 5; i++) begin
            bus.call = 1'b1;
            bus.jmp_target = 32'(i * 16);
            tick();
            clear_ctl();
            if (i == 4) begin
                n_vec++; if (bus.ras_full !== RAS) begin n_err++; $display("FAIL four_calls_full: got %b want %b", bus.ras_full, RAS); end
                n_vec++; if (bus.ras_ovf !== 1'b0) begin n_err++; $display("FAIL four_calls_ovf: got %b want 0", bus.ras_ovf); end
            end
        end
        n_vec++; if (bus.pc !== 32'h50) begin n_err++; $display("FAIL five_calls_pc: got %h want %h", bus.pc, 32'h50); end
        n_vec++; if (bus.ras_ovf !== RAS) begin n_err++; $display("FAIL five_calls_ovf: got %b want %b", bus.ras_ovf, RAS); end
        n_vec++; if (bus.ras_full !== RAS) begin n_err++; $display("FAIL five_calls_full: got %b want %b", bus.ras_full, RAS); end
        for (int i = 0; i < 4; i++) begin
            bus.ret = 1'b1;
            bus.jmp_target = 32'h600 + 32'(i);
            tick();
            clear_ctl();
            n_vec++; if (bus.pc !== (RAS ? exp_ret[i] : 32'h600 + 32'(i))) begin n_err++; $display("FAIL ret%0d_pc: got %h want %h", i, bus.pc, (RAS ? exp_ret[i] : 32'h600 + 32'(i))); end
        end
        n_vec++; if (bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL drained_empty: got %b want 1", bus.ras_empty); end
        bus.ret = 1'b1;
        bus.jmp_target = 32'h500;
        tick();
        clear_ctl();
        n_vec++; if (bus.pc !== 32'h500) begin n_err++; $display("FAIL unf_pc: got %h want %h", bus.pc, 32'h500); end
        n_vec++; if (bus.ras_unf !== RAS) begin n_err++; $display("FAIL unf_pulse: got %b want %b", bus.ras_unf, RAS); end
        tick();
        n_vec++; if (bus.ras_unf !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b want 0", bus.ras_unf); end
        n_vec++; if (bus.pc !== 32'h501) begin n_err++; $display("FAIL after_unf_pc: got %h want %h", bus.pc, 32'h501); end
        n_vec++; if (bus.ras_ovf !== RAS) begin n_err++; $display("FAIL ovf_sticky: got %b want %b", bus.ras_ovf, RAS); end
    endtask

    task automatic test_async_reset();
        jump_to(32'h30);
        bus.call = 1'b1;
        bus.jmp_target = 32'h35;
        tick();
        bus.jmp_target = 32'h36;
        tick();
        clear_ctl();
        tick();
        n_vec++; if (bus.pc !== 32'h37) begin n_err++; $display("FAIL pre_reset_pc: got %h want %h", bus.pc, 32'h37); end
        n_vec++; if (bus.ras_empty !== !RAS) begin n_err++; $display("FAIL pre_reset_empty: got %b want %b", bus.ras_empty, !RAS); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.pc !== 32'h100) begin n_err++; $display("FAIL async_reset_pc: got %h want %h", bus.pc, 32'h100); end
        n_vec++; if (bus.pc_plus !== 32'h101) begin n_err++; $display("FAIL async_reset_pc_plus: got %h want %h", bus.pc_plus, 32'h101); end
        n_vec++; if ({bus.ras_empty, bus.ras_full, bus.ras_ovf} !== 3'b100) begin n_err++; $display("FAIL async_reset_flags: got %b want 100", {bus.ras_empty, bus.ras_full, bus.ras_ovf}); end
        tick();
        rst_n = 1'b1;
        bus.stall = 1'b1;
        tick();
        n_vec++; if (bus.pc !== 32'h100) begin n_err++; $display("FAIL release_stall_pc: got %h want %h", bus.pc, 32'h100); end
        bus.stall = 1'b0;
        tick();
        n_vec++; if (bus.pc !== 32'h101) begin n_err++; $display("FAIL release_run_pc: got %h want %h", bus.pc, 32'h101); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_run();
        test_stall_branch();
        test_wrap();
        test_call_ret();
        test_ovf_unf();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the MIPS fetch stage. Holds the current word address and selects the next one each cycle from sequential increment, hold (stall), taken branch, jump/call, or return. Calls and returns are served by an optional circular return-address stack. Word addressing is used throughout: sequential step is INC words, not bytes.

## Interface
- ADDR_W, 32: PC width in bits.
- RESET_VEC, 0: PC value on reset; truncated to ADDR_W.
- INC, 1: sequential step in words.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥2; used only with PC_RAS_EN.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- br_taken  in  1  branch resolved taken.
- br_target  in  ADDR_W  branch destination.
- jmp_en  in  1  unconditional jump (j).
- call  in  1  jump-and-link (jal): jump to jmp_target, push return address.
- ret  in  1  return (jr $ra): jump to popped address.
- jmp_target  in  ADDR_W  jump/call destination; also ret fallback.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus  out  ADDR_W  pc + INC (registered alongside pc).
- ras_empty  out  1  stack holds no entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky: a push overwrote an entry.
- ras_unf  out  1  one-cycle pulse: ret taken with stack empty.

## Operation
- Next-PC priority per cycle: br_taken > ret > call > jmp_en > stall > sequential.
  - br_taken: pc ← br_target; no push/pop even if call/ret also high.
  - ret: pc ← popped top; if stack empty, pc ← jmp_target and ras_unf pulses.
  - call: pc ← jmp_target; push pc + INC (address after the call).
  - jmp_en: pc ← jmp_target.
  - stall: pc and stack unchanged.
  - none: pc ← pc + INC.
- Redirects override stall.
- call and ret together: ret wins; no push.
- Arithmetic modulo 2^ADDR_W: pc = all-ones with INC=1 wraps to 0. pc_plus always equals pc + INC mod 2^ADDR_W.
- Stack is circular, with a top pointer and a count 0..RAS_DEPTH.
  - Push when full overwrites the oldest entry: count stays at RAS_DEPTH, ras_ovf sets and holds until reset.
  - Pop decrements count and returns the most recent entry.
- Reset values: pc = RESET_VEC, pc_plus = RESET_VEC + INC, ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0. Pointer and count are cleared.

## Timing
- All inputs are sampled on the rising edge of clk. The selected address appears on pc one cycle later; redirect latency is 1 cycle.
- Push and pop commit on the same edge as the redirect. ras_empty and ras_full reflect the post-update count in that same cycle.
- ras_unf is high for exactly the cycle after the offending edge.
- Asserting rst at any point clears state immediately, without waiting for clk. Deasserting rst takes effect at the next rising edge: the first edge after release advances pc to RESET_VEC + INC, or holds it if stall is high.
- No combinational path from any input to any output.

## Configuration
- PC_RAS_EN defined: return-address stack is instantiated and behaves as above.
- PC_RAS_EN undefined:
  - No stack storage.
  - ret behaves exactly as jmp_en, using jmp_target.
  - call is a plain jump with no push.
  - ras_empty is tied to 1; ras_full, ras_ovf and ras_unf are tied to 0.

## Structure
- Shared package pc_pkg holds:
  - the next-PC select enum: SEL_SEQ, SEL_HOLD, SEL_BR, SEL_RET, SEL_CALL, SEL_JMP;
  - default constants for RESET_VEC and INC.
- One sub-module, ras_stack, parametrised by ADDR_W and RAS_DEPTH. It owns storage, pointer, count, overflow and underflow logic, and is instantiated only under PC_RAS_EN.

## Test plan
- Reset and run: rst low, then released with RESET_VEC=0x100 and no controls asserted -> pc reads 0x100, 0x101, 0x102 on successive edges; pc_plus is always pc+1.
- Stall vs branch:
  - stall high for 3 cycles at pc=0x104 -> pc holds 0x104.
  - stall and br_taken with br_target=0x200 on the same edge -> pc=0x200 on the next cycle.
- Wrap-around: pc=0xFFFFFFFF with INC=1 -> next pc=0x0 and pc_plus=0x1.
- Call/return: call at pc=0x10 (jmp_target 0x80), then ret at pc=0x85 -> pc=0x80, then pc=0x11; ras_empty returns to 1.
- Overflow/underflow (RAS_DEPTH=4):
  - 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_ovf=1.
  - 4 rets -> pc returns to 0x41, 0x31, 0x21, 0x11.
  - 5th ret with jmp_target=0x500 -> pc=0x500 and ras_unf pulses for one cycle.
- Async reset mid-run: rst asserted between edges at pc=0x37 with 2 stack entries -> pc=RESET_VEC before the next edge; ras_empty=1 and ras_ovf=0.
